id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded operands, immediate, PC, register addresses and control bits from ID, and presents them to EX.
- Generates the 2-bit forwarding selects and the load-use hazard flag that drive the EX-stage 4-input operand muxes and the stall logic.
- Its data and select outputs feed the operand muxes directly: rs1/rs2 data on input 0, and the selects on the select input.

---
 rtl/id_ex_stage_reg_if.sv | 54 +++++
 rtl/id_ex_stage_reg.sv | 119 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bundle: ID-side fields, hazard controls, write-back
// tags from later stages, and the registered EX-side view with forwarding selects.
interface id_ex_stage_reg_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 10
);
  logic                hold_i;
  logic                flush_i;
  logic                id_valid_i;
  logic [DATA_LEN-1:0] id_pc_i;
  logic [DATA_LEN-1:0] id_rs1_data_i;
  logic [DATA_LEN-1:0] id_rs2_data_i;
  logic [DATA_LEN-1:0] id_imm_i;
  logic [ADDR_W-1:0]   id_rs1_addr_i;
  logic [ADDR_W-1:0]   id_rs2_addr_i;
  logic [ADDR_W-1:0]   id_rd_addr_i;
  logic [CTRL_W-1:0]   id_ctrl_i;
  logic                exmem_reg_write_i;
  logic [ADDR_W-1:0]   exmem_rd_i;
  logic                memwb_reg_write_i;
  logic [ADDR_W-1:0]   memwb_rd_i;

  logic                ex_valid_o;
  logic [DATA_LEN-1:0] ex_pc_o;
  logic [DATA_LEN-1:0] ex_rs1_data_o;
  logic [DATA_LEN-1:0] ex_rs2_data_o;
  logic [DATA_LEN-1:0] ex_imm_o;
  logic [ADDR_W-1:0]   ex_rs1_addr_o;
  logic [ADDR_W-1:0]   ex_rs2_addr_o;
  logic [ADDR_W-1:0]   ex_rd_addr_o;
  logic [CTRL_W-1:0]   ex_ctrl_o;
  logic [1:0]          forward_a_o;
  logic [1:0]          forward_b_o;
  logic                load_use_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i,
           exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i,
    input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o,
           forward_a_o, forward_b_o, load_use_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i,
           exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i,
    output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o,
           forward_a_o, forward_b_o, load_use_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage RISC-V core, with operand forwarding
// selects and load-use detection derived from the registered EX slot.
module id_ex_stage_reg #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 10
) (
  input logic              clk_i,
  input logic              rst_i,
  id_ex_stage_reg_if.slave bus
);
  localparam int CTRL_MEM_READ = 2;

  logic                valid_r;
  logic [DATA_LEN-1:0] pc_r;
  logic [DATA_LEN-1:0] rs1_data_r;
  logic [DATA_LEN-1:0] rs2_data_r;
  logic [DATA_LEN-1:0] imm_r;
  logic [ADDR_W-1:0]   rs1_addr_r;
  logic [ADDR_W-1:0]   rs2_addr_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [CTRL_W-1:0]   ctrl_r;

  logic [1:0] forward_a_s;
  logic [1:0] forward_b_s;
  logic       load_use_s;

  // EX/MEM beats MEM/WB; x0 is hard-wired zero so it never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic              slot_valid,
    input logic [ADDR_W-1:0] src,
    input logic              exmem_we,
    input logic [ADDR_W-1:0] exmem_rd,
    input logic              memwb_we,
    input logic [ADDR_W-1:0] memwb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!slot_valid) begin
      sel = 2'b00;
    end else if (exmem_we && (exmem_rd != {ADDR_W{1'b0}}) && (exmem_rd == src)) begin
      sel = 2'b10;
    end else if (memwb_we && (memwb_rd != {ADDR_W{1'b0}}) && (memwb_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Pipeline register: hold > flush > load, with bubbles normalised to zero control.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r    <= 1'b0;
      pc_r       <= {DATA_LEN{1'b0}};
      rs1_data_r <= {DATA_LEN{1'b0}};
      rs2_data_r <= {DATA_LEN{1'b0}};
      imm_r      <= {DATA_LEN{1'b0}};
      rs1_addr_r <= {ADDR_W{1'b0}};
      rs2_addr_r <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      ctrl_r     <= {CTRL_W{1'b0}};
    end else if (bus.hold_i) begin
      valid_r    <= valid_r;
      pc_r       <= pc_r;
      rs1_data_r <= rs1_data_r;
      rs2_data_r <= rs2_data_r;
      imm_r      <= imm_r;
      rs1_addr_r <= rs1_addr_r;
      rs2_addr_r <= rs2_addr_r;
      rd_addr_r  <= rd_addr_r;
      ctrl_r     <= ctrl_r;
    end else if (bus.flush_i) begin
      valid_r    <= 1'b0;
      pc_r       <= {DATA_LEN{1'b0}};
      rs1_data_r <= {DATA_LEN{1'b0}};
      rs2_data_r <= {DATA_LEN{1'b0}};
      imm_r      <= {DATA_LEN{1'b0}};
      rs1_addr_r <= {ADDR_W{1'b0}};
      rs2_addr_r <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      ctrl_r     <= {CTRL_W{1'b0}};
    end else begin
      valid_r    <= bus.id_valid_i;
      pc_r       <= bus.id_pc_i;
      rs1_data_r <= bus.id_rs1_data_i;
      rs2_data_r <= bus.id_rs2_data_i;
      imm_r      <= bus.id_imm_i;
      rs1_addr_r <= bus.id_rs1_addr_i;
      rs2_addr_r <= bus.id_rs2_addr_i;
      rd_addr_r  <= bus.id_rd_addr_i;
      ctrl_r     <= bus.id_valid_i ? bus.id_ctrl_i : {CTRL_W{1'b0}};
    end
  end

  // Forwarding selects and load-use flag; valid_r is 0 during reset so these read 0.
  always_comb begin
    forward_a_s = fwd_sel(valid_r, rs1_addr_r, bus.exmem_reg_write_i, bus.exmem_rd_i,
                          bus.memwb_reg_write_i, bus.memwb_rd_i);
    forward_b_s = fwd_sel(valid_r, rs2_addr_r, bus.exmem_reg_write_i, bus.exmem_rd_i,
                          bus.memwb_reg_write_i, bus.memwb_rd_i);
    load_use_s  = valid_r & ctrl_r[CTRL_MEM_READ] & (rd_addr_r != {ADDR_W{1'b0}}) &
                  bus.id_valid_i &
                  ((rd_addr_r == bus.id_rs1_addr_i) | (rd_addr_r == bus.id_rs2_addr_i));
  end

  assign bus.ex_valid_o    = valid_r;
  assign bus.ex_pc_o       = pc_r;
  assign bus.ex_rs1_data_o = rs1_data_r;
  assign bus.ex_rs2_data_o = rs2_data_r;
  assign bus.ex_imm_o      = imm_r;
  assign bus.ex_rs1_addr_o = rs1_addr_r;
  assign bus.ex_rs2_addr_o = rs2_addr_r;
  assign bus.ex_rd_addr_o  = rd_addr_r;
  assign bus.ex_ctrl_o     = ctrl_r;
  assign bus.forward_a_o   = forward_a_s;
  assign bus.forward_b_o   = forward_b_s;
  assign bus.load_use_o    = load_use_s;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: register load/hold/flush, forwarding
// priority, load-use detection and asynchronous reset.
module tb_id_ex_stage_reg;
  localparam int DATA_LEN = 32;
  localparam int ADDR_W   = 5;
  localparam int CTRL_W   = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  id_ex_stage_reg_if #(.DATA_LEN(DATA_LEN), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();

  id_ex_stage_reg #(.DATA_LEN(DATA_LEN), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctrl);
    bus.id_valid_i    = v;
    bus.id_pc_i       = pc;
    bus.id_rs1_data_i = pc + 32'h0000_1000;
    bus.id_rs2_data_i = pc + 32'h0000_2000;
    bus.id_imm_i      = pc + 32'h0000_3000;
    bus.id_rs1_addr_i = rs1;
    bus.id_rs2_addr_i = rs2;
    bus.id_rd_addr_i  = rd;
    bus.id_ctrl_i     = ctrl;
  endtask

  task automatic set_wb(input logic em_we, input logic [4:0] em_rd,
                        input logic mw_we, input logic [4:0] mw_rd);
    bus.exmem_reg_write_i = em_we;
    bus.exmem_rd_i        = em_rd;
    bus.memwb_reg_write_i = mw_we;
    bus.memwb_rd_i        = mw_rd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    drive_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 10'h000);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    step();
    step();
    check_eq("rst_valid", {31'd0, bus.ex_valid_o}, 32'h0);
    check_eq("rst_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h0);
    check_eq("rst_fa", {30'd0, bus.forward_a_o}, 32'h0);
    check_eq("rst_lu", {31'd0, bus.load_use_o}, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("rel_pc", bus.ex_pc_o, 32'h0);
    check_eq("rel_fb", {30'd0, bus.forward_b_o}, 32'h0);

    // First instruction: one-cycle latency
    drive_id(1'b1, 32'h100, 5'd7, 5'd9, 5'd5, 10'h005);
    step();
    check_eq("load_pc", bus.ex_pc_o, 32'h100);
    check_eq("load_rd", {27'd0, bus.ex_rd_addr_o}, 32'd5);
    check_eq("load_valid", {31'd0, bus.ex_valid_o}, 32'h1);
    check_eq("load_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h005);
    check_eq("load_imm", bus.ex_imm_o, 32'h3100);
    check_eq("load_rs2d", bus.ex_rs2_data_o, 32'h2100);

    // Forwarding priority on rs1=7, rs2=9
    set_wb(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check_eq("fwd_both_a", {30'd0, bus.forward_a_o}, 32'd2);
    check_eq("fwd_both_b", {30'd0, bus.forward_b_o}, 32'd0);
    set_wb(1'b0, 5'd7, 1'b1, 5'd7);
    #1;
    check_eq("fwd_memwb_a", {30'd0, bus.forward_a_o}, 32'd1);
    set_wb(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check_eq("fwd_x0_a", {30'd0, bus.forward_a_o}, 32'd0);
    set_wb(1'b1, 5'd9, 1'b1, 5'd7);
    #1;
    check_eq("fwd_split_a", {30'd0, bus.forward_a_o}, 32'd1);
    check_eq("fwd_split_b", {30'd0, bus.forward_b_o}, 32'd2);

    // Load-use: a load writing x3 in EX
    drive_id(1'b1, 32'h104, 5'd7, 5'd9, 5'd3, 10'h004);
    step();
    drive_id(1'b1, 32'h108, 5'd1, 5'd3, 5'd4, 10'h001);
    #1;
    check_eq("lu_rs2", {31'd0, bus.load_use_o}, 32'h1);
    bus.id_rs2_addr_i = 5'd4;
    #1;
    check_eq("lu_nomatch", {31'd0, bus.load_use_o}, 32'h0);
    bus.id_rs1_addr_i = 5'd3;
    bus.id_valid_i    = 1'b0;
    #1;
    check_eq("lu_idinv", {31'd0, bus.load_use_o}, 32'h0);
    bus.id_valid_i = 1'b1;
    set_wb(1'b1, 5'd7, 1'b1, 5'd9);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check_eq("fl_valid", {31'd0, bus.ex_valid_o}, 32'h0);
    check_eq("fl_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h0);
    check_eq("fl_pc", bus.ex_pc_o, 32'h0);
    check_eq("fl_fa", {30'd0, bus.forward_a_o}, 32'd0);
    check_eq("fl_fb", {30'd0, bus.forward_b_o}, 32'd0);

    // Hold has priority over flush
    drive_id(1'b1, 32'h200, 5'd7, 5'd2, 5'd6, 10'h001);
    step();
    check_eq("h_pre_pc", bus.ex_pc_o, 32'h200);
    drive_id(1'b1, 32'h300, 5'd8, 5'd8, 5'd8, 10'h011);
    bus.hold_i  = 1'b1;
    bus.flush_i = 1'b1;
    step();
    check_eq("h_pc", bus.ex_pc_o, 32'h200);
    check_eq("h_valid", {31'd0, bus.ex_valid_o}, 32'h1);
    check_eq("h_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h001);
    check_eq("h_fa", {30'd0, bus.forward_a_o}, 32'd2);
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    step();
    check_eq("h_rel_pc", bus.ex_pc_o, 32'h300);
    check_eq("h_rel_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h011);

    // Invalid ID slot: control normalised to a bubble
    drive_id(1'b0, 32'h400, 5'd7, 5'd7, 5'd7, 10'h3FF);
    step();
    check_eq("inv_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h0);
    check_eq("inv_valid", {31'd0, bus.ex_valid_o}, 32'h0);
    check_eq("inv_pc", bus.ex_pc_o, 32'h400);
    check_eq("inv_fa", {30'd0, bus.forward_a_o}, 32'd0);

    // Asynchronous reset between edges
    drive_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd3, 10'h005);
    step();
    check_eq("ar_pre_valid", {31'd0, bus.ex_valid_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", {31'd0, bus.ex_valid_o}, 32'h0);
    check_eq("ar_pc", bus.ex_pc_o, 32'h0);
    check_eq("ar_ctrl", {22'd0, bus.ex_ctrl_o}, 32'h0);
    #1;
    rst = 1'b0;
    step();
    check_eq("ar_reload_pc", bus.ex_pc_o, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
